// File: rtl/sim_uart_line_buffer.sv
// Console line buffer behind the SimTop UART pair.
// Bytes are held in a FIFO and released to the printer in whole committed segments.
module sim_uart_line_buffer #(
    parameter  int DEPTH       = 64,
    parameter  int IDLE_CYCLES = 1000,
    localparam int LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_ch,
    input  logic             flush_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_ch,
    output logic             out_last,
    output logic [LVL_W-1:0] level,
    output logic [31:0]      drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    logic [7:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  pending_q, pending_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [31:0]       drop_q, drop_d;

    logic accept;
    logic pop;
    logic commit;
    logic has_partial;

    assign out_valid  = (pending_q != '0);
    assign out_ch     = mem_q[rd_ptr_q];
    assign out_last   = out_valid && (pending_q == LVL_ONE);
    assign level      = level_q;
    assign drop_count = drop_q;

    // Full check uses the registered level so a same-cycle pop never frees a slot.
    assign accept      = in_valid && (level_q < LVL_FULL);
    assign pop         = out_valid && out_ready;
    assign has_partial = (level_q > pending_q);

    always_comb begin
        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!accept && pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_comb begin
        commit = 1'b0;
        if (accept && (in_ch == 8'h0A)) begin
            commit = 1'b1;
        end
        if (accept && (level_d == LVL_FULL)) begin
            commit = 1'b1;
        end
        if ((idle_q == IDLE_MAX) && has_partial) begin
            commit = 1'b1;
        end
        if (flush_req) begin
            commit = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        idle_d    = idle_q;
        drop_d    = drop_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            pending_d = pending_q - LVL_ONE;
        end
        if (commit) begin
            pending_d = level_d;
        end
        if (in_valid && !accept && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
        if (accept || commit || !has_partial) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pending_q <= '0;
            idle_q    <= '0;
            drop_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pending_q <= pending_d;
            idle_q    <= idle_d;
            drop_q    <= drop_d;
        end
    end

    // Storage is data only; pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= in_ch;
        end
    end

endmodule

// File: tb/tb_sim_uart_line_buffer.sv
// Directed bench for sim_uart_line_buffer: a DEPTH=64 instance and a DEPTH=4 instance.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_sim_uart_line_buffer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic        flush_req;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        out_last;
    logic [6:0]  level;
    logic [31:0] drop_count;

    logic        s_in_valid;
    logic [7:0]  s_in_ch;
    logic        s_out_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_ch;
    logic        s_out_last;
    logic [2:0]  s_level;
    logic [31:0] s_drop_count;

    int nvec;
    int nerr;

    sim_uart_line_buffer #(.DEPTH(64), .IDLE_CYCLES(8)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .level      (level),
        .drop_count (drop_count)
    );

    sim_uart_line_buffer #(.DEPTH(4), .IDLE_CYCLES(8)) u_small (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (s_in_valid),
        .in_ch      (s_in_ch),
        .flush_req  (1'b0),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_ch     (s_out_ch),
        .out_last   (s_out_last),
        .level      (s_level),
        .drop_count (s_drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] ch);
        in_valid = 1'b1;
        in_ch    = ch;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] ch, input logic last);
        nvec++;
        if (out_valid !== 1'b1 || out_ch !== ch || out_last !== last) begin
            nerr++;
            $display("FAIL %s: got v=%b ch=%h last=%b, want v=1 ch=%h last=%b",
                     nm, out_valid, out_ch, out_last, ch, last);
        end
    endtask

    task automatic expect_empty(input string nm);
        nvec++;
        if (out_valid !== 1'b0 || level !== 7'd0) begin
            nerr++;
            $display("FAIL %s: got v=%b level=%0d, want v=0 level=0", nm, out_valid, level);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        nvec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || level !== 7'd0 || drop_count !== 32'd0) begin
            nerr++;
            $display("FAIL reset: got v=%b last=%b level=%0d drop=%0d, want 0 0 0 0",
                     out_valid, out_last, level, drop_count);
        end
        nvec++;
        if (s_out_valid !== 1'b0 || s_level !== 3'd0 || s_drop_count !== 32'd0) begin
            nerr++;
            $display("FAIL reset_small: got v=%b level=%0d drop=%0d, want 0 0 0",
                     s_out_valid, s_level, s_drop_count);
        end
    endtask

    task automatic test_newline();
        out_ready = 1'b1;
        wr(8'h68);
        nvec++;
        if (out_valid !== 1'b0 || level !== 7'd1) begin
            nerr++;
            $display("FAIL nl_partial: got v=%b level=%0d, want v=0 level=1", out_valid, level);
        end
        wr(8'h69);
        wr(8'h0A);
        expect_byte("nl_b0", 8'h68, 1'b0);
        tick();
        expect_byte("nl_b1", 8'h69, 1'b0);
        tick();
        expect_byte("nl_b2", 8'h0A, 1'b1);
        tick();
        expect_empty("nl_done");
    endtask

    task automatic test_idle_timeout();
        bit early;
        out_ready = 1'b1;
        wr(8'h61);
        wr(8'h62);
        wr(8'h63);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        nvec++;
        if (early) begin
            nerr++;
            $display("FAIL idle_early: got out_valid=1 within 8 idle cycles, want 0");
        end
        tick();
        expect_byte("idle_b0", 8'h61, 1'b0);
        tick();
        expect_byte("idle_b1", 8'h62, 1'b0);
        tick();
        expect_byte("idle_b2", 8'h63, 1'b1);
        tick();
        expect_empty("idle_done");
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ch;
        s_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_in_valid = 1'b1;
            s_in_ch    = 8'h41 + 8'(i);
            tick();
        end
        s_in_valid = 1'b0;
        nvec++;
        if (s_level !== 3'd4 || s_drop_count !== 32'd2 || s_out_valid !== 1'b1 || s_out_ch !== 8'h41) begin
            nerr++;
            $display("FAIL ovf_state: got level=%0d drop=%0d v=%b ch=%h, want 4 2 1 41",
                     s_level, s_drop_count, s_out_valid, s_out_ch);
        end
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ch = 8'h41 + 8'(i);
            nvec++;
            if (s_out_valid !== 1'b1 || s_out_ch !== exp_ch || s_out_last !== (i == 3)) begin
                nerr++;
                $display("FAIL ovf_b%0d: got v=%b ch=%h last=%b, want v=1 ch=%h last=%b",
                         i, s_out_valid, s_out_ch, s_out_last, exp_ch, (i == 3));
            end
            tick();
        end
        nvec++;
        if (s_out_valid !== 1'b0 || s_level !== 3'd0) begin
            nerr++;
            $display("FAIL ovf_done: got v=%b level=%0d, want 0 0", s_out_valid, s_level);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [5];
        int k;
        int pops;
        int cyc;
        exp[0] = 8'h61;
        exp[1] = 8'h62;
        exp[2] = 8'h63;
        exp[3] = 8'h64;
        exp[4] = 8'h0A;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(exp[i]);
        k    = 0;
        pops = 0;
        cyc  = 0;
        while (k < 5 && cyc < 40) begin
            nvec++;
            if (out_valid !== 1'b1 || out_ch !== exp[k] || out_last !== (k == 4)) begin
                nerr++;
                $display("FAIL stall_b%0d: got v=%b ch=%h last=%b, want v=1 ch=%h last=%b",
                         k, out_valid, out_ch, out_last, exp[k], (k == 4));
            end
            out_ready = cyc[0];
            tick();
            if (cyc[0]) begin
                k++;
                pops++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        nvec++;
        if (pops != 5) begin
            nerr++;
            $display("FAIL stall_pops: got %0d, want 5", pops);
        end
        expect_empty("stall_done");
    endtask

    task automatic test_extend();
        out_ready = 1'b1;
        wr(8'h61);
        wr(8'h62);
        wr(8'h0A);
        expect_byte("ext_b0", 8'h61, 1'b0);
        wr(8'h78);
        expect_byte("ext_b1", 8'h62, 1'b0);
        wr(8'h0A);
        expect_byte("ext_b2", 8'h0A, 1'b0);
        tick();
        expect_byte("ext_b3", 8'h78, 1'b0);
        tick();
        expect_byte("ext_b4", 8'h0A, 1'b1);
        tick();
        expect_empty("ext_done");
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        wr(8'h71);
        wr(8'h72);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL flush_pre: got v=%b, want 0", out_valid);
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        expect_byte("flush_b0", 8'h71, 1'b0);
        tick();
        expect_byte("flush_b1", 8'h72, 1'b1);
        tick();
        expect_empty("flush_done");
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(8'h30 + 8'(i));
        wr(8'h0A);
        nvec++;
        if (level !== 7'd10 || out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL rmd_pre: got level=%0d v=%b, want 10 1", level, out_valid);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        nvec++;
        if (out_valid !== 1'b0 || level !== 7'd0 || drop_count !== 32'd0 || out_last !== 1'b0) begin
            nerr++;
            $display("FAIL rmd_post: got v=%b level=%0d drop=%0d last=%b, want 0 0 0 0",
                     out_valid, level, drop_count, out_last);
        end
        tick();
        expect_empty("rmd_quiet");
        wr(8'h7A);
        wr(8'h0A);
        expect_byte("rmd_b0", 8'h7A, 1'b0);
        tick();
        expect_byte("rmd_b1", 8'h0A, 1'b1);
        tick();
        expect_empty("rmd_done");
    endtask

    initial begin
        nvec        = 0;
        nerr        = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_ch       = 8'h00;
        flush_req   = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_ch     = 8'h00;
        s_out_ready = 1'b0;
        #1;
        test_reset();
        test_newline();
        test_idle_timeout();
        test_overflow();
        test_stall();
        test_extend();
        test_flush();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
